// File: rtl/mem_bank_ctrl.sv
// ============================================================================
// Module  : mem_bank_ctrl
// Brief   : Parametrised single-port memory bank with a valid/ready request
//           channel and a one-cycle response pulse. Optional per-byte parity
//           (macro MEM_PARITY_EN) adds the err_inj port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bank_ctrl #(
  parameter int    DATA_W    = 256,
  parameter int    ADDR_W    = 8,
  parameter int    DEPTH     = 256,
  parameter int    RD_LAT    = 1,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef MEM_PARITY_EN
  input  logic                err_inj,
`endif
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_rw,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int               c_NB       = DATA_W / 8;
  localparam int               c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  c_DEPTH_EX = (ADDR_W + 1)'(DEPTH);
  localparam logic [1:0]       c_CNT_INIT = 2'(RD_LAT - 1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_RD_WAIT = 1'b1
  } state_t;

  state_t              r_state, w_stateNxt;
  logic [1:0]          r_cnt, w_cntNxt;
  logic                w_rspValidNxt, w_rspErrNxt;
  logic [DATA_W-1:0]   w_rspDataNxt;
  logic [DATA_W-1:0]   r_capData;
  logic                r_capErr;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                w_inRange, w_wrAccept, w_rdAccept, w_parErr;
  logic [c_IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0]   w_rdWord;

  assign w_inRange  = ({1'b0, req_addr} < c_DEPTH_EX);
  assign w_idx      = req_addr[c_IDX_W-1:0];
  assign w_wrAccept = req_valid & req_ready & ~req_rw;
  assign w_rdAccept = req_valid & req_ready & req_rw;
  assign w_rdWord   = r_mem[w_idx];

`ifdef MEM_PARITY_EN
  logic [c_NB-1:0] r_par [DEPTH];

  // Even parity: stored bit equals the XOR of the byte, so a clean byte XORs to 0.
  always_comb begin
    w_parErr = 1'b0;
    for (int i = 0; i < c_NB; i++) begin
      w_parErr = w_parErr | ((^w_rdWord[8*i +: 8]) ^ r_par[w_idx][i]);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wrAccept && w_inRange) begin
      for (int i = 0; i < c_NB; i++) begin
        if (req_be[i]) begin
          r_par[w_idx][i] <= (^req_wdata[8*i +: 8]) ^ err_inj;
        end
      end
    end
  end
`else
  assign w_parErr = 1'b0;
`endif

  // Storage and read capture carry no reset; the array value at accept is what returns.
  always_ff @(posedge clk) begin
    if (w_wrAccept && w_inRange) begin
      for (int i = 0; i < c_NB; i++) begin
        if (req_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
    if (w_rdAccept) begin
      r_capData <= w_inRange ? w_rdWord : '0;
      r_capErr  <= ~w_inRange | w_parErr;
    end
  end

  always_comb begin
    w_stateNxt    = r_state;
    w_cntNxt      = r_cnt;
    req_ready     = 1'b0;
    busy          = 1'b0;
    w_rspValidNxt = 1'b0;
    w_rspErrNxt   = 1'b0;
    w_rspDataNxt  = rsp_rdata;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_rw) begin
            w_stateNxt = S_RD_WAIT;
            w_cntNxt   = c_CNT_INIT;
          end else begin
            w_rspValidNxt = 1'b1;
            w_rspErrNxt   = ~w_inRange;
          end
        end
      end
      S_RD_WAIT: begin
        busy = 1'b1;
        if (r_cnt == 2'd0) begin
          w_stateNxt    = S_IDLE;
          w_rspValidNxt = 1'b1;
          w_rspErrNxt   = r_capErr;
          w_rspDataNxt  = r_capData;
        end else begin
          w_cntNxt = r_cnt - 2'd1;
        end
      end
      default: w_stateNxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 2'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      r_state   <= w_stateNxt;
      r_cnt     <= w_cntNxt;
      rsp_valid <= w_rspValidNxt;
      rsp_err   <= w_rspErrNxt;
      rsp_rdata <= w_rspDataNxt;
    end
  end

endmodule

`default_nettype wire
